uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised oversampling UART receiver; successor to the single-rate receiver in the serial link path. Recovers asynchronous frames with configurable data width, parity mode and stop-bit count, majority-votes each bit at its centre, and flags parity, framing and overrun errors. Received words pass through a small FIFO to a valid/ready consumer, so downstream stalls of up to FIFO_DEPTH frames lose no data.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9, LSB first on the line.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- PARITY_MODE, 0: 0 none, 1 even, 2 odd.
- BAUD_RATE, 9600: line bit rate.
- CLK_FREQ, 50000000: clk frequency in Hz.
- OVERSAMPLE, 16: sample ticks per bit, even, ≥8.
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥2.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  head-of-FIFO data word.
- parity_err  out  1  head word had a parity mismatch (always 0 when PARITY_MODE=0).
- frame_err  out  1  head word had at least one stop bit sampled low.
- valid  out  1  FIFO not empty; data_out/parity_err/frame_err are meaningful.
- ready  in  1  consumer accepts head word when valid && ready.
- overrun  out  1  one-clk pulse: completed frame dropped because FIFO full.
- busy  out  1  FSM not in IDLE.

## Operation
- rx passes a 2-flop synchroniser (both flops reset to 1); all logic uses the synchronised rx_s.
- Tick divider: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated, minimum 1; free-running counter emits a one-clk tick every DIV clks. All FSM activity is qualified by tick; the FSM runs on clk (no derived clocks).
- Per-bit sample counter os_cnt 0..OVERSAMPLE-1. Samples captured at os_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; bit value = majority of the three; decision at os_cnt = OVERSAMPLE/2+1; bit ends at os_cnt = OVERSAMPLE-1 (os_cnt wraps to 0).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a tick with rx_s=0 -> START, os_cnt=0 (that tick counts as sample 0).
- START: majority 1 at decision -> IDLE (glitch rejected, nothing pushed). Else at bit end -> DATA, bit_cnt=0.
- DATA: at decision, shift bit into shift register MSB, right-shifting (LSB first); XOR into running parity. At bit end: bit_cnt==DATA_BITS-1 -> PARITY if PARITY_MODE≠0 else STOP; otherwise bit_cnt+1.
- PARITY: at decision, parity_err = (xor of data and parity bit) ≠ (PARITY_MODE==2 ? 1 : 0). Bit end -> STOP, bit_cnt=0.
- STOP: each stop bit sampled; any majority 0 sets frame_err. At the decision of the last stop bit (not bit end): push {frame_err, parity_err, data} and -> IDLE, allowing resync on a start edge in the remaining half bit.
- FIFO: push writes tail; pop on valid && ready. Push when full without a same-cycle pop: word dropped, overrun pulses one clk, contents unchanged. Push and pop in the same cycle when full: both occur, no overrun. Words emerge in arrival order.
- Error flags are per word, cleared at each frame start, never sticky across words.

## Timing
- Reset (reset=0, async): state IDLE, counters 0, FIFO empty; valid, data_out, parity_err, frame_err, overrun, busy all 0. Deassertion is synchronised to clk internally before use.
- Reset mid-frame: partial frame discarded; no push, no overrun.
- rx to rx_s: 2 clk. valid rises on the clk after the push cycle; data_out stable while valid && !ready.
- Frame latency: start edge to valid ≈ (1 + DATA_BITS + parity + STOP_BITS − 0.5) bit times + 3 clk.
- busy asserts the clk after the start tick, drops the clk after the push.
- Tolerates ±3% baud mismatch at OVERSAMPLE=16 over a 12-bit frame.

## Test plan
- CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 (DIV=10), 8N1, ready=1; send 0xA5 -> one valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
- PARITY_MODE=1; send 0x03 with parity bit 1 (wrong) -> data_out=0x03, parity_err=1; repeat with parity bit 0 -> parity_err=0. PARITY_MODE=2, 0x03 with parity 1 -> parity_err=0.
- 8N1, send 0x3C with stop bit driven 0 -> data_out=0x3C, frame_err=1; next correct frame 0x3C -> frame_err=0.
- rx pulsed low for 4 ticks (40 clk) -> no word, busy returns to 0, FSM in IDLE; following 0x81 frame received correctly.
- ready=0, FIFO_DEPTH=4; send 0x01..0x05 -> valid=1, overrun pulses exactly once (during frame 5); raise ready -> 0x01,0x02,0x03,0x04 popped in order, then valid=0.
- Assert reset during data bit 3 of 0x5A -> all outputs 0 immediately; release, send 0xC3 -> only 0xC3 delivered, no errors.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Consumer-side bundle of the oversampling UART receiver: head-of-FIFO word,
// its error flags and the valid/ready handshake.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;
    logic                 frame_err;
    logic                 valid;
    logic                 ready;

    modport master (output data_out, parity_err, frame_err, valid, input ready);
    modport slave  (input data_out, parity_err, frame_err, valid, output ready);
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted bit recovery, parity/framing/overrun
// detection and a small output FIFO towards a valid/ready consumer.
module uart_rx_os #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0,
    parameter int BAUD_RATE   = 9600,
    parameter int CLK_FREQ    = 50000000,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    uart_rx_os_if.master out_if,
    output logic         overrun,
    output logic         busy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int WORD_W  = DATA_BITS + 2;
    localparam logic [OS_W-1:0] S0      = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] S1      = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] S2      = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic            ODD     = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             rx_meta, rx_s;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    state_t               state, state_n;
    logic [OS_W-1:0]      os_cnt, os_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_acc, par_n;
    logic [1:0]           samp, samp_n;
    logic                 perr, perr_n, ferr, ferr_n;
    logic                 maj, push;
    logic [WORD_W-1:0]    push_word;

    // The third vote is the live synchronised sample taken on the decision tick.
    assign maj = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_acc <= 1'b0;
            samp    <= 2'b11;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_n;
            os_cnt  <= os_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            par_acc <= par_n;
            samp    <= samp_n;
            perr    <= perr_n;
            ferr    <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        os_n    = os_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par_acc;
        samp_n  = samp;
        perr_n  = perr;
        ferr_n  = ferr;
        push    = 1'b0;
        if (tick) begin
            if (state == IDLE) begin
                if (!rx_s) begin
                    state_n = START;
                    os_n    = '0;
                    bit_n   = '0;
                    par_n   = 1'b0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end else begin
                os_n = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                if (os_cnt == S0) samp_n[0] = rx_s;
                if (os_cnt == S1) samp_n[1] = rx_s;
                case (state)
                    START: begin
                        if (os_cnt == S2 && maj) begin
                            state_n = IDLE;
                        end else if (os_cnt == OS_LAST) begin
                            state_n = DATA;
                            bit_n   = '0;
                        end
                    end
                    DATA: begin
                        if (os_cnt == S2) begin
                            shift_n = {maj, shift[DATA_BITS-1:1]};
                            par_n   = par_acc ^ maj;
                        end
                        if (os_cnt == OS_LAST) begin
                            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                                state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                                bit_n   = '0;
                            end else begin
                                bit_n = bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                    PARITY: begin
                        if (os_cnt == S2)      perr_n = par_acc ^ maj ^ ODD;
                        if (os_cnt == OS_LAST) begin
                            state_n = STOP;
                            bit_n   = '0;
                        end
                    end
                    STOP: begin
                        // Last stop bit completes at its centre so a new start edge can follow at once.
                        if (os_cnt == S2) begin
                            if (!maj) ferr_n = 1'b1;
                            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                                push    = 1'b1;
                                state_n = IDLE;
                            end
                        end
                        if (os_cnt == OS_LAST) bit_n = bit_cnt + BIT_W'(1);
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
        push_word = {ferr_n, perr_n, shift_n};
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full, pop, do_push;
    logic [WORD_W-1:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = !empty && out_if.ready;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            overrun <= push && full && !pop;
        end
    end

    // Outputs are forced to zero while empty so reset and idle both read as 0.
    assign out_if.valid      = !empty;
    assign out_if.data_out   = empty ? '0   : head[DATA_BITS-1:0];
    assign out_if.parity_err = empty ? 1'b0 : head[DATA_BITS];
    assign out_if.frame_err  = empty ? 1'b0 : head[DATA_BITS+1];
    assign busy              = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three receivers (8N1, 8E1, 8O1) on separate
// lines; expected words are queued as frames are driven and popped on handshake.
module tb_uart_rx_os;
    localparam int BIT_CLKS = 160;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rxLine [3];
    logic ovr [3];
    logic busyS [3];
    int   checks = 0;
    int   errors = 0;
    int   ovrCount = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    uart_rx_os_if #(.DATA_BITS(8)) if0();
    uart_rx_os_if #(.DATA_BITS(8)) if1();
    uart_rx_os_if #(.DATA_BITS(8)) if2();

    uart_rx_os #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(0), .BAUD_RATE(10000),
                 .CLK_FREQ(1600000), .OVERSAMPLE(16), .FIFO_DEPTH(4))
        dut0 (.clk(clk), .reset(reset), .rx(rxLine[0]), .out_if(if0.master),
              .overrun(ovr[0]), .busy(busyS[0]));
    uart_rx_os #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(1), .BAUD_RATE(10000),
                 .CLK_FREQ(1600000), .OVERSAMPLE(16), .FIFO_DEPTH(4))
        dut1 (.clk(clk), .reset(reset), .rx(rxLine[1]), .out_if(if1.master),
              .overrun(ovr[1]), .busy(busyS[1]));
    uart_rx_os #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(2), .BAUD_RATE(10000),
                 .CLK_FREQ(1600000), .OVERSAMPLE(16), .FIFO_DEPTH(4))
        dut2 (.clk(clk), .reset(reset), .rx(rxLine[2]), .out_if(if2.master),
              .overrun(ovr[2]), .busy(busyS[2]));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Each consumer pops on negedge when a handshake is about to complete.
    always @(negedge clk) begin
        if (if0.valid && if0.ready) begin
            if (q0.size() == 0) checkOutput("dut0Underflow", q0.size(), 1);
            else checkOutput("dut0Word", {if0.frame_err, if0.parity_err, if0.data_out}, q0.pop_front());
        end
        if (if1.valid && if1.ready) begin
            if (q1.size() == 0) checkOutput("dut1Underflow", q1.size(), 1);
            else checkOutput("dut1Word", {if1.frame_err, if1.parity_err, if1.data_out}, q1.pop_front());
        end
        if (if2.valid && if2.ready) begin
            if (q2.size() == 0) checkOutput("dut2Underflow", q2.size(), 1);
            else checkOutput("dut2Word", {if2.frame_err, if2.parity_err, if2.data_out}, q2.pop_front());
        end
        if (ovr[0]) ovrCount++;
    end

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input int idx, input logic val);
        rxLine[idx] = val;
        waitClks(BIT_CLKS);
    endtask

    // Sends one frame on line idx; when expectWord is set the word the bench predicts is queued.
    task automatic applyStimulus(input int idx, input logic [7:0] data, input bit hasParity,
                                 input bit parityBit, input bit stopVal, input bit expectWord);
        logic [9:0] w;
        logic       perr;
        perr = 1'b0;
        if (idx == 1) perr = (^data) ^ parityBit;
        if (idx == 2) perr = ~((^data) ^ parityBit);
        w = {~stopVal, perr, data};
        if (expectWord) begin
            case (idx)
                0:       q0.push_back(w);
                1:       q1.push_back(w);
                default: q2.push_back(w);
            endcase
        end
        driveBit(idx, 1'b0);
        for (int b = 0; b < 8; b++) driveBit(idx, data[b]);
        if (hasParity) driveBit(idx, parityBit);
        driveBit(idx, stopVal);
        driveBit(idx, 1'b1);
    endtask

    task automatic waitDrain(input int idx);
        for (int i = 0; i < 2000 && qsize(idx) != 0; i++) @(posedge clk);
        #1;
        checkOutput("drain", qsize(idx), 0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) rxLine[i] = 1'b1;
        if0.ready = 1'b1;
        if1.ready = 1'b1;
        if2.ready = 1'b1;
        reset = 1'b0;
        waitClks(5);
        checkOutput("rstValid", if0.valid, 0);
        checkOutput("rstData", if0.data_out, 0);
        checkOutput("rstPerr", if1.parity_err, 0);
        checkOutput("rstFerr", if0.frame_err, 0);
        checkOutput("rstOverrun", ovr[0], 0);
        checkOutput("rstBusy", busyS[0], 0);
        reset = 1'b1;
        waitClks(20);

        applyStimulus(0, 8'hA5, 0, 0, 1, 1);
        waitDrain(0);

        applyStimulus(1, 8'h03, 1, 1, 1, 1);
        applyStimulus(1, 8'h03, 1, 0, 1, 1);
        waitDrain(1);
        applyStimulus(2, 8'h03, 1, 1, 1, 1);
        applyStimulus(2, 8'h03, 1, 0, 1, 1);
        waitDrain(2);

        applyStimulus(0, 8'h3C, 0, 0, 0, 1);
        applyStimulus(0, 8'h3C, 0, 0, 1, 1);
        waitDrain(0);

        rxLine[0] = 1'b0;
        waitClks(35);
        checkOutput("glitchBusy", busyS[0], 1);
        waitClks(5);
        rxLine[0] = 1'b1;
        waitClks(300);
        checkOutput("glitchIdle", busyS[0], 0);
        checkOutput("glitchNoWord", if0.valid, 0);
        applyStimulus(0, 8'h81, 0, 0, 1, 1);
        waitDrain(0);

        if0.ready = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(0, 8'(i), 0, 0, 1, 1);
        checkOutput("noEarlyOverrun", ovrCount, 0);
        applyStimulus(0, 8'h05, 0, 0, 1, 0);
        checkOutput("overrunOnce", ovrCount, 1);
        checkOutput("fullValid", if0.valid, 1);
        checkOutput("stallHead", if0.data_out, 1);
        if0.ready = 1'b1;
        waitDrain(0);
        waitClks(2);
        checkOutput("fifoEmpty", if0.valid, 0);

        driveBit(0, 1'b0);
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        driveBit(0, 1'b0);
        rxLine[0] = 1'b1;
        waitClks(BIT_CLKS / 2);
        checkOutput("midFrameBusy", busyS[0], 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstBusy", busyS[0], 0);
        checkOutput("midRstValid", if0.valid, 0);
        checkOutput("midRstOverrun", ovr[0], 0);
        waitClks(10);
        reset = 1'b1;
        waitClks(20);
        applyStimulus(0, 8'hC3, 0, 0, 1, 1);
        waitDrain(0);

        waitClks(10);
        checkOutput("q0Final", q0.size(), 0);
        checkOutput("q1Final", q1.size(), 0);
        checkOutput("q2Final", q2.size(), 0);
        checkOutput("overrunTotal", ovrCount, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
